// File: rtl/rpn_ctrl.sv
// RPN command controller: parses ASCII tokens from the UART receiver, drives the operand
// stack write port, evaluates + - * on the top two entries and offers results to the TX side.
module rpn_ctrl #(
  parameter int STACK_ADDR_WIDTH = 5,
  parameter int STACK_DEPTH      = 2**STACK_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] st_first,
  input  logic [15:0] st_second,
  output logic        st_wen,
  output logic [15:0] st_din,
  output logic [1:0]  st_pop_cnt,
  output logic [15:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        err
);

  localparam int DATA_W  = 16;
  localparam int DEPTH_W = STACK_ADDR_WIDTH + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_NUM, S_PUSH, S_EXEC, S_EMIT, S_CLEAR
  } state_t;

  typedef enum logic [2:0] {
    C_DIGIT, C_SEP, C_OP, C_EMIT, C_CLR, C_ILL
  } cls_t;

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [7:0]          tok;
  logic [DEPTH_W-1:0]  depth;
  logic [DEPTH_W-1:0]  flush_cnt;

  function automatic cls_t classify(input logic [7:0] b);
    cls_t c;
    if (b >= 8'h30 && b <= 8'h39) begin
      c = C_DIGIT;
    end else begin
      case (b)
        8'h20, 8'h0D:        c = C_SEP;
        8'h2B, 8'h2D, 8'h2A: c = C_OP;
        8'h3D, 8'h0A:        c = C_EMIT;
        8'h43:               c = C_CLR;
        default:             c = C_ILL;
      endcase
    end
    return c;
  endfunction

  // Decimal accumulate; wraps modulo 2^16 like the datapath.
  function automatic logic [DATA_W-1:0] mac10(input logic [DATA_W-1:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + {12'd0, d};
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [7:0] op,
                                            input logic [DATA_W-1:0] sec,
                                            input logic [DATA_W-1:0] fst);
    logic [DATA_W-1:0] r;
    case (op)
      8'h2B:   r = sec + fst;
      8'h2D:   r = sec - fst;
      default: r = sec * fst;
    endcase
    return r;
  endfunction

  assign rx_ready = (state == S_IDLE) || (state == S_NUM);

  always_comb begin
    st_wen     = 1'b0;
    st_din     = '0;
    st_pop_cnt = 2'd0;
    case (state)
      S_INIT:  st_pop_cnt = 2'd1;
      S_PUSH: begin
        if (depth != DEPTH_MAX) begin
          st_wen = 1'b1;
          st_din = acc;
        end
      end
      S_EXEC: begin
        if (classify(tok) == C_OP && depth >= DEPTH_TWO) begin
          st_wen     = 1'b1;
          st_pop_cnt = 2'd2;
          st_din     = alu(tok, st_second, st_first);
        end
      end
      S_CLEAR: st_pop_cnt = 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_INIT;
      acc       <= '0;
      depth     <= '0;
      flush_cnt <= '0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        // The stack itself has no reset: pop it empty before trusting depth.
        S_INIT: begin
          if (flush_cnt == DEPTH_MAX - DEPTH_ONE) state <= S_IDLE;
          else                                    flush_cnt <= flush_cnt + DEPTH_ONE;
        end
        S_IDLE: begin
          if (rx_valid) begin
            case (classify(rx_data))
              C_DIGIT: begin
                acc   <= {12'd0, rx_data[3:0]};
                state <= S_NUM;
              end
              C_SEP: ;
              C_OP, C_EMIT, C_CLR: begin
                tok   <= rx_data;
                state <= S_EXEC;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_NUM: begin
          if (rx_valid) begin
            case (classify(rx_data))
              C_DIGIT: acc <= mac10(acc, rx_data[3:0]);
              C_SEP, C_OP, C_EMIT, C_CLR: begin
                tok   <= rx_data;
                state <= S_PUSH;
              end
              default: begin
                err   <= 1'b1;
                acc   <= '0;
                state <= S_IDLE;
              end
            endcase
          end
        end
        S_PUSH: begin
          if (depth == DEPTH_MAX) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            depth <= depth + DEPTH_ONE;
            state <= (classify(tok) == C_SEP) ? S_IDLE : S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_IDLE;
          case (classify(tok))
            C_OP: begin
              if (depth < DEPTH_TWO) err <= 1'b1;
              else                   depth <= depth - DEPTH_ONE;
            end
            C_EMIT: begin
              if (depth == '0) begin
                err <= 1'b1;
              end else begin
                res_data  <= st_first;
                res_valid <= 1'b1;
                state     <= S_EMIT;
              end
            end
            C_CLR: begin
              err <= 1'b0;
              if (depth != '0) state <= S_CLEAR;
            end
            default: ;
          endcase
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_CLEAR: begin
          depth <= depth - DEPTH_ONE;
          if (depth == DEPTH_ONE) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_ctrl.sv
// Bench for rpn_ctrl: a behavioural stack drives st_first/st_second, a token-level RPN model
// predicts stack operations and results, and directed strings pin the model with literals.
module tb_rpn_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] st_first, st_second;
  logic        st_wen;
  logic [15:0] st_din;
  logic [1:0]  st_pop_cnt;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        err;

  rpn_ctrl #(.STACK_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .st_first(st_first), .st_second(st_second),
    .st_wen(st_wen), .st_din(st_din), .st_pop_cnt(st_pop_cnt),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  // Stack with no reset; starts holding stale entries.
  logic [15:0] mem [0:31];
  logic [5:0]  sp = 6'd7;
  logic [5:0]  sp_pop;
  always_comb sp_pop = ({4'd0, st_pop_cnt} > sp) ? 6'd0 : sp - {4'd0, st_pop_cnt};
  always @(posedge clk) begin
    if (st_wen && sp_pop < 6'd32) begin
      mem[sp_pop[4:0]] <= st_din;
      sp <= sp_pop + 6'd1;
    end else begin
      sp <= sp_pop;
    end
  end
  assign st_first  = (sp >= 6'd1) ? mem[5'(sp - 6'd1)] : 16'h0;
  assign st_second = (sp >= 6'd2) ? mem[5'(sp - 6'd2)] : 16'h0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Token-level model
  typedef struct {
    logic       wen;
    logic [1:0] pop;
    logic [15:0] din;
  } op_t;

  op_t     exp_ops[$];
  longint  exp_res[$];
  longint  m_stk[$];
  longint  m_acc;
  bit      m_in_num;
  bit      m_err;

  task automatic model_reset();
    exp_ops.delete(); exp_res.delete(); m_stk.delete();
    m_acc = 0; m_in_num = 0; m_err = 0;
  endtask

  task automatic model_feed(input logic [7:0] b);
    longint a, f, r;
    op_t o;
    if (b >= "0" && b <= "9") begin
      m_acc = m_in_num ? ((m_acc * 10 + longint'(b - "0")) % 65536) : longint'(b - "0");
      m_in_num = 1;
      return;
    end
    if (!(b == " " || b == 8'h0D || b == "+" || b == "-" || b == "*" ||
          b == "=" || b == 8'h0A || b == "C")) begin
      m_err = 1; m_in_num = 0;
      return;
    end
    if (m_in_num) begin
      m_in_num = 0;
      if (m_stk.size() == 32) begin
        m_err = 1;
        return;
      end
      m_stk.push_back(m_acc);
      o.wen = 1; o.pop = 2'd0; o.din = 16'(m_acc);
      exp_ops.push_back(o);
    end
    if (b == "+" || b == "-" || b == "*") begin
      if (m_stk.size() < 2) begin
        m_err = 1;
      end else begin
        f = m_stk.pop_back();
        a = m_stk.pop_back();
        if (b == "+")      r = (a + f) % 65536;
        else if (b == "-") r = (a - f + 65536) % 65536;
        else               r = (a * f) % 65536;
        m_stk.push_back(r);
        o.wen = 1; o.pop = 2'd2; o.din = 16'(r);
        exp_ops.push_back(o);
      end
    end else if (b == "=" || b == 8'h0A) begin
      if (m_stk.size() == 0) m_err = 1;
      else exp_res.push_back(m_stk[m_stk.size() - 1]);
    end else if (b == "C") begin
      m_err = 0;
      while (m_stk.size() > 0) begin
        void'(m_stk.pop_back());
        o.wen = 0; o.pop = 2'd1; o.din = 16'h0;
        exp_ops.push_back(o);
      end
    end
  endtask

  // Compare process
  bit          flushing = 1;
  bit          prev_rv = 0;
  logic [31:0] last_res = 32'hFFFF_FFFF;

  always @(negedge clk) begin
    op_t e;
    if (rst_n && !flushing) begin
      if (st_wen || st_pop_cnt != 2'd0) begin
        chk("pop_le_depth", 32'({4'd0, st_pop_cnt} <= sp), 32'd1);
        chk("no_push_when_full", 32'(st_wen && st_pop_cnt == 2'd0 && sp == 6'd32), 32'd0);
        if (exp_ops.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_stack_op: got wen=%0d pop=%0d din=%0d required none",
                   st_wen, st_pop_cnt, st_din);
        end else begin
          e = exp_ops.pop_front();
          chk("stack_wen", 32'(st_wen), 32'(e.wen));
          chk("stack_pop_cnt", 32'(st_pop_cnt), 32'(e.pop));
          chk("stack_din", 32'(st_din), 32'(e.din));
        end
      end
      if (res_valid && !prev_rv) begin
        last_res = 32'(res_data);
        if (exp_res.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got %0d required none", res_data);
        end else begin
          chk("res_data", 32'(res_data), 32'(exp_res.pop_front()));
        end
      end
      if (res_valid) chk("rx_ready_in_emit", 32'(rx_ready), 32'd0);
    end
    prev_rv = res_valid;
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
      return;
    end
    model_feed(b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic settle(input string name);
    repeat (40) @(negedge clk);
    chk({name, "_ops_drained"}, 32'(exp_ops.size()), 32'd0);
    chk({name, "_res_drained"}, 32'(exp_res.size()), 32'd0);
    chk({name, "_err"}, 32'(err), 32'(m_err));
    chk({name, "_depth"}, 32'(sp), 32'(m_stk.size()));
  endtask

  task automatic do_reset();
    int t = 0;
    int cnt = 0;
    flushing = 1;
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_wen", 32'(st_wen), 32'd0);
    rst_n = 1'b1;
    while (!rx_ready && t < 100) begin
      if (st_pop_cnt == 2'd1 && !st_wen) cnt++;
      @(negedge clk);
      t++;
    end
    chk("init_pops", 32'(cnt), 32'd32);
    chk("init_rx_ready", 32'(rx_ready), 32'd1);
    chk("init_stack_empty", 32'(sp), 32'd0);
    model_reset();
    flushing = 0;
  endtask

  task automatic run_res(input string s, input logic [31:0] want);
    last_res = 32'hFFFF_FFFF;
    send_str(s);
    settle(s);
    chk({"lit_", s}, last_res, want);
  endtask

  initial begin
    int t;
    model_reset();
    do_reset();

    run_res("12 34+=", 32'd46);
    run_res("3 5-=", 32'd65534);
    run_res("65535 1+=", 32'd0);
    run_res("70000=", 32'd4464);
    run_res("6 7*=", 32'd42);
    run_res("300 300*=", 32'd24464);
    run_res("8\r2*\n", 32'd16);
    send_str("C");
    settle("clear7");
    chk("lit_clear7_depth", 32'(sp), 32'd0);

    run_res("9q5=", 32'd5);
    chk("lit_illegal_err", 32'(err), 32'd1);
    send_str("C");
    settle("clr_err");
    chk("lit_clr_err", 32'(err), 32'd0);

    do_reset();
    send_str("+");
    settle("underflow_op");
    chk("lit_underflow_err", 32'(err), 32'd1);
    send_str("C");
    settle("clr_after_underflow");
    chk("lit_underflow_clr", 32'(err), 32'd0);

    for (int i = 0; i < 33; i++) send_str("1 ");
    settle("fill33");
    chk("lit_overflow_err", 32'(err), 32'd1);
    chk("lit_overflow_depth", 32'(sp), 32'd32);
    send_str("5+");
    settle("full_num_op");
    run_res("=", 32'd1);
    send_str("C");
    settle("clear32");
    chk("lit_clear32_depth", 32'(sp), 32'd0);

    res_ready = 1'b0;
    send_str("7=");
    t = 0;
    while (!res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("hold_seen", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'd7);
      chk("hold_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("hold_released", 32'(res_valid), 32'd0);
    settle("hold");

    send_str("C");
    settle("pre_pop3");
    send_str("1 2 3C=");
    settle("pop3");
    chk("lit_pop3_err", 32'(err), 32'd1);

    res_ready = 1'b0;
    send_str("7=");
    t = 0;
    while (!res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("emit_before_reset", 32'(res_valid), 32'd1);
    do_reset();
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_res_valid", 32'(res_valid), 32'd0);
    run_res("2 3+=", 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
